// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with run/done handshake and match counting
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_we,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic [WIN_W-1:0]               cfg_window,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           x,
  input  logic                           x_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           z,
  output logic [CNT_W-1:0]               match_count,
  output logic                           cfg_err
);
  localparam int LW = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0] len_q, len_d, fill_q, fill_d, eff_len;
  logic ovl_q, ovl_d, err_q, err_d;
  logic [WIN_W-1:0] win_q, win_d, bcnt_q, bcnt_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAX_LEN-1:0] cand, mask;
  logic fill_ok, len_ok;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign match_count = cnt_q;
  assign cfg_err = err_q;
  // Mealy match: newest bit plus history, compared over the low L bits once enough bits are held
  always_comb begin
    cand = {hist_q, x};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len_q);
    fill_ok = ({1'b0, fill_q} + (LW+1)'(1)) >= {1'b0, len_q};
    z = (state_q == RUN) && x_valid && fill_ok && (((cand ^ pat_q) & mask) == '0);
    eff_len = cfg_we ? cfg_len : len_q;
    len_ok = (eff_len != '0) && (int'(eff_len) <= MAX_LEN);
  end
  // Next state: config load and start validation in IDLE, shifting and counting in RUN
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    win_d = win_q;
    err_d = err_q;
    hist_d = hist_q;
    fill_d = fill_q;
    bcnt_d = bcnt_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          ovl_d = cfg_overlap;
          win_d = cfg_window;
          err_d = 1'b0;
        end
        if (start && len_ok) begin
          state_d = RUN;
          cnt_d = '0;
          hist_d = '0;
          fill_d = '0;
          bcnt_d = '0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      RUN: begin
        if (x_valid) begin
          hist_d = cand[MAX_LEN-2:0];
          fill_d = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
          bcnt_d = bcnt_q + WIN_W'(1);
          if (z) begin
            cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
            fill_d = ovl_q ? fill_d : '0;
          end
          state_d = (win_q != '0 && bcnt_d == win_q) ? DONE : state_d;
        end
        state_d = abort ? DONE : state_d;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers with synchronous reset to the default 0110/L=4 config
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q <= MAX_LEN'(4'b0110);
      len_q <= LW'(4);
      ovl_q <= 1'b1;
      win_q <= '0;
      err_q <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      bcnt_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      win_q <= win_d;
      err_q <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      bcnt_q <= bcnt_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed scenarios plus randomized run against a queue-based reference model
module tb_seq_detect_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b1, start = 1'b0, abort = 1'b0, x = 1'b0, x_valid = 1'b0;
  logic [7:0] cfg_pattern = 8'h06;
  logic [3:0] cfg_len = 4'd4;
  logic [15:0] cfg_window = 16'd0;
  logic busy, done, z, cfg_err, busy2, done2, z2, cfg_err2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  int n_checks = 0, n_fail = 0;
  int m_state, m_len, m_win, m_bits, m_cnt, m_cnt2;
  logic [7:0] m_pat;
  bit m_ovl, m_err;
  bit m_q[$];
  logic zo, zo2, ze;
  logic [63:0] zvo;
  seq_detect_ctrl dut (.clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_window(cfg_window), .start(start), .abort(abort), .x(x), .x_valid(x_valid),
    .busy(busy), .done(done), .z(z), .match_count(match_count), .cfg_err(cfg_err));
  seq_detect_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_window(cfg_window), .start(start), .abort(abort), .x(x), .x_valid(x_valid),
    .busy(busy2), .done(done2), .z(z2), .match_count(match_count2), .cfg_err(cfg_err2));
  always #5 clk = ~clk;
  task automatic model_reset();
    m_state = 0; m_pat = 8'h06; m_len = 4; m_ovl = 1; m_win = 0;
    m_q.delete(); m_bits = 0; m_cnt = 0; m_cnt2 = 0; m_err = 0;
  endtask
  function automatic bit model_z(bit xv, bit xb);
    bit b;
    if (m_state != 1 || !xv || m_q.size() < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? xb : m_q[m_q.size() - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction
  task automatic model_update(bit rs, bit we, bit st, bit ab, bit xv, bit xb, bit zm);
    if (rs) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        if (we) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_win = int'(cfg_window); m_err = 0;
        end
        if (st && m_len >= 1 && m_len <= 8) begin
          m_state = 1; m_cnt = 0; m_cnt2 = 0; m_q.delete(); m_bits = 0;
        end else if (st) m_err = 1;
      end
      1: begin
        if (xv) begin
          m_q.push_back(xb);
          m_bits++;
          if (zm) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!m_ovl) m_q.delete();
          end
          while (m_q.size() > 8) void'(m_q.pop_front());
          if (m_win != 0 && m_bits == m_win) m_state = 2;
        end
        if (ab) m_state = 2;
      end
      default: m_state = 0;
    endcase
  endtask
  task automatic step(bit rs, bit we, bit st, bit ab, bit xv, bit xb);
    @(negedge clk);
    reset = rs; cfg_we = we; start = st; abort = ab; x_valid = xv; x = xb;
    #1;
    ze = model_z(xv, xb);
    zo = z;
    zo2 = z2;
    zvo = {zvo[62:0], zo};
    @(posedge clk);
    model_update(rs, we, st, ab, xv, xb, ze);
    #1;
  endtask
  task automatic set_cfg(logic [7:0] p, logic [3:0] l, logic o, logic [15:0] w);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_window = w;
  endtask
  task automatic feed7(logic [6:0] s);
    for (int i = 6; i >= 0; i--) step(0, 0, 0, 0, 1, s[i]);
  endtask
  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", match_count); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", cfg_err); end
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z got %b want 0", z); end
  endtask
  task automatic test_overlap();
    set_cfg(8'h06, 4'd4, 1'b1, 16'd7);
    step(0, 1, 1, 0, 0, 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovl_busy got %b want 1", busy); end
    zvo = '0;
    feed7(7'b0110110);
    n_checks++; if (zvo[6:0] !== 7'b0001001) begin n_fail++; $display("FAIL ovl_z got %b want 0001001", zvo[6:0]); end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ovl_done got done=%b busy=%b want 1/0", done, busy); end
    n_checks++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL ovl_count got %0d want 2", match_count); end
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || match_count !== 8'd2) begin n_fail++; $display("FAIL ovl_idle got done=%b busy=%b cnt=%0d want 0/0/2", done, busy, match_count); end
  endtask
  task automatic test_no_overlap();
    set_cfg(8'h06, 4'd4, 1'b0, 16'd7);
    step(0, 1, 1, 0, 0, 0);
    zvo = '0;
    feed7(7'b0110110);
    n_checks++; if (zvo[6:0] !== 7'b0001000) begin n_fail++; $display("FAIL novl_z got %b want 0001000", zvo[6:0]); end
    n_checks++; if (match_count !== 8'd1 || done !== 1'b1) begin n_fail++; $display("FAIL novl_count got cnt=%0d done=%b want 1/1", match_count, done); end
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_gaps();
    logic [4:0] s = 5'b10101;
    set_cfg(8'h05, 4'd3, 1'b1, 16'd0);
    step(0, 1, 1, 0, 0, 0);
    zvo = '0;
    for (int i = 0; i < 9; i++) step(0, 0, 0, i == 8, i % 2 == 0, (i % 2 == 0) ? s[4 - i / 2] : 1'b1);
    n_checks++; if (zvo[8:0] !== 9'b000010001) begin n_fail++; $display("FAIL gaps_z got %b want 000010001", zvo[8:0]); end
    n_checks++; if (match_count !== 8'd2 || done !== 1'b1) begin n_fail++; $display("FAIL gaps_end got cnt=%0d done=%b want 2/1", match_count, done); end
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (done !== 1'b0 || match_count !== 8'd2) begin n_fail++; $display("FAIL gaps_hold got done=%b cnt=%0d want 0/2", done, match_count); end
  endtask
  task automatic test_cfg_err();
    set_cfg(8'h06, 4'd0, 1'b1, 16'd0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_len0 got err=%b busy=%b want 1/0", cfg_err, busy); end
    set_cfg(8'h06, 4'd9, 1'b1, 16'd0);
    step(0, 1, 1, 0, 0, 0);
    n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_len9 got err=%b busy=%b want 1/0", cfg_err, busy); end
    set_cfg(8'h06, 4'd4, 1'b1, 16'd0);
    step(0, 1, 0, 0, 0, 0);
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", cfg_err); end
    step(0, 0, 1, 0, 0, 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL err_start got busy=%b want 1", busy); end
    step(0, 0, 0, 1, 0, 0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL err_abort got done=%b want 1", done); end
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_saturate();
    set_cfg(8'h01, 4'd1, 1'b1, 16'd6);
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);
    set_cfg(8'h00, 4'd2, 1'b0, 16'd2);
    step(0, 1, 0, 0, 1, 1);
    n_checks++; if (match_count !== 8'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL sat_cfgrun got cnt=%0d busy=%b want 4/1", match_count, busy); end
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 1);
    n_checks++; if (done !== 1'b1 || match_count !== 8'd6) begin n_fail++; $display("FAIL sat_done got done=%b cnt=%0d want 1/6", done, match_count); end
    n_checks++; if (match_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count2 got %0d want 3", match_count2); end
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset_midrun();
    set_cfg(8'h06, 4'd4, 1'b1, 16'd7);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    n_checks++; if (busy !== 1'b0 || match_count !== 8'd0) begin n_fail++; $display("FAIL rst_mid got busy=%b cnt=%0d want 0/0", busy, match_count); end
    step(0, 0, 1, 0, 0, 0);
    zvo = '0;
    feed7(7'b0110110);
    n_checks++; if (zvo[6:0] !== 7'b0001001 || match_count !== 8'd2) begin n_fail++; $display("FAIL rst_rerun got z=%b cnt=%0d want 0001001/2", zvo[6:0], match_count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_window got busy=%b want 1", busy); end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      set_cfg(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom), 16'($urandom_range(0, 12)));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
      n_checks++; if (zo !== ze || zo2 !== ze) begin n_fail++; $display("FAIL rnd_z cyc %0d got %b/%b want %b", n, zo, zo2, ze); end
      n_checks++; if (busy !== (m_state == 1) || done !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_state cyc %0d got busy=%b done=%b want state %0d", n, busy, done, m_state); end
      n_checks++; if (match_count !== 8'(m_cnt) || match_count2 !== 2'(m_cnt2)) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d/%0d want %0d/%0d", n, match_count, match_count2, m_cnt, m_cnt2); end
      n_checks++; if (cfg_err !== m_err || cfg_err2 !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b/%b want %b", n, cfg_err, cfg_err2, m_err); end
    end
  endtask
  initial begin
    model_reset();
    zvo = '0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_cfg_err();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-sequence detection controller with a run/done handshake. It holds a software-loaded pattern (1..MAX_LEN bits), length and overlap mode. It accepts one bit per qualified cycle from a serial input and raises a Mealy match pulse. It counts matches over a programmable bit window and signals completion. It replaces the fixed-pattern detectors with one configurable, sequenced instance.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
WIN_W, 16, window length counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cfg_we  input  1  config write strobe; accepted only in IDLE
cfg_pattern  input  MAX_LEN  pattern; bit L-1 = first bit received, bit 0 = last
cfg_len  input  $clog2(MAX_LEN+1)  pattern length L
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_window  input  WIN_W  bits per run; 0 = unlimited (ends only on abort)
start  input  1  begin a run (IDLE only)
abort  input  1  end the current run early
x  input  1  serial data bit
x_valid  input  1  x is consumed this cycle
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
z  output  1  Mealy match pulse (combinational from x, x_valid, state)
match_count  output  CNT_W  matches in the current or last run
cfg_err  output  1  sticky; start rejected due to invalid L

Behaviour:
- Reset (sync, priority over everything). State=IDLE. pattern=0110 (low 4 bits, rest 0), L=4, overlap=1, window=0. History and fill=0, bit counter=0, match_count=0, cfg_err=0. busy=0, done=0, z=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - cfg_we latches pattern, L, overlap and window, and clears cfg_err.
  - start with L in 1..MAX_LEN goes to RUN. It clears match_count, history, fill and the bit counter.
  - start with L=0 or L>MAX_LEN stays in IDLE and sets cfg_err.
  - cfg_we and start in the same cycle: the config is latched first, and start is validated against the new L.
- RUN:
  - busy=1. cfg_we and start are ignored.
  - On x_valid, x shifts into the LSB of the history register. fill increments and saturates at MAX_LEN. The bit counter increments.
- Match rule:
  - z = (state==RUN) & x_valid & (fill >= L-1) & ({hist, x}[L-1:0] == pattern[L-1:0]).
  - L=1 matches on every bit equal to pattern[0].
- On a match:
  - match_count increments and saturates at 2^CNT_W-1.
  - If overlap=0, fill is cleared to 0 so that no bit is shared between matches.
  - If overlap=1, the history is kept.
- Ending a run:
  - If window!=0 and a consumed bit makes bit counter == window, go to DONE next cycle. That last bit is still evaluated for a match.
  - abort in RUN goes to DONE next cycle. A bit consumed in the same cycle as abort is still evaluated.
  - x_valid=0 means no shift, no count and z=0.
- DONE: done=1 for exactly one cycle, then IDLE. x is ignored and z=0.
- match_count holds its value from DONE until the next accepted start.
- Reset asserted mid-run returns to IDLE and clears the counters and the config.
- Latency:
  - z is in the same cycle as the matching bit.
  - match_count updates on the following edge.
  - done is one cycle after the last bit or abort.

Test Plan:
1. Reset, then start with defaults (0110, L=4, overlap=1, window=7); feed 0,1,1,0,1,1,0 with x_valid=1 -> z high on bits 4 and 7, match_count=2, done pulses one cycle after bit 7, busy=0 after done.
2. Same stream with cfg_overlap=0 loaded in IDLE -> z only on bit 4, match_count=1.
3. Config pattern 101, L=3, window=0; feed 1,0,1,0,1 with gaps (x_valid low between bits); abort after bit 5 -> matches on bits 3 and 5, count=2, z never high while x_valid=0.
4. cfg_len=0 then start -> stays IDLE, cfg_err=1, busy=0. Next valid cfg_we -> cfg_err=0, and start is accepted.
5. CNT_W=2, pattern 1, L=1, window=6, all ones -> count saturates at 3 and done fires after bit 6. Separately, cfg_we during RUN changes nothing.
6. Assert reset after bit 3 of scenario 1 -> IDLE, count=0, config back to default; rerun scenario 1 gives count=2.
